// File: rtl/xor_64bit.sv
// Registered bitwise-XOR leaf of the Y86-64 ALU (xorq): out = A ^ B one cycle
// after a valid operand pair, with zero/sign/overflow condition codes.
module xor_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  // Handshake: in_valid qualifies A/B in the cycle it is high; there is no
  // ready, every valid pair is accepted and yields exactly one out_valid pulse
  // on the following cycle. While in_valid is low, out and flags hold.

  logic [WIDTH-1:0] xor_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_xor_cell
    assign xor_w[i] = A[i] ^ B[i];
  end

  logic [WIDTH-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;
  logic             zf_d, zf_q;
  logic             sf_d, sf_q;

  // Flags come from the same xor_w that loads out, so they can never disagree.
  always_comb begin
    out_d       = out_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = xor_w;
      zf_d  = (xor_w == '0);
      sf_d  = xor_w[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  // XOR cannot overflow.
  assign of        = 1'b0;

endmodule

// File: tb/tb_xor_64bit.sv
// Directed bench for xor_64bit: hand-computed vectors checked with immediate
// assertions, sampled on the falling edge between rising edges.
module tb_xor_64bit;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         out_valid;
  logic         zf;
  logic         sf;
  logic         of;

  int n_checks;
  int n_fail;

  xor_64bit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a),
    .B        (b),
    .out      (out),
    .out_valid(out_valid),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [W-1:0] e_out, input logic e_valid,
                            input logic e_zf, input logic e_sf);
    check({tag, ".out"},       out,                  e_out);
    check({tag, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, e_valid});
    check({tag, ".zf"},        {{(W-1){1'b0}}, zf},  {{(W-1){1'b0}}, e_zf});
    check({tag, ".sf"},        {{(W-1){1'b0}}, sf},  {{(W-1){1'b0}}, e_sf});
    check({tag, ".of"},        {{(W-1){1'b0}}, of},  {W{1'b0}});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    tick();
    expect_all("reset", 64'h0, 1'b0, 1'b1, 1'b0);

    // Reset released and first operand pair presented at the same point.
    rst_n = 1'b1;
    drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    tick();
    expect_all("max_pos", 64'h7FFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    expect_all("min_neg", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 64'h0000_0000_01A1_91A6, 64'hFFFF_FFFD_2CE8_D4C1);
    tick();
    expect_all("mixed", 64'hFFFF_FFFD_2D49_4567, 1'b1, 1'b0, 1'b1);

    // Back-to-back small values with in_valid held high.
    drive(1'b1, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    expect_all("b2b_0", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_0000);
    tick();
    expect_all("b2b_1", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b1);

    // Negative result, then drop in_valid: value and flags must hold.
    drive(1'b0, 64'hAAAA_5555_0000_FFFF, 64'h1111_2222_3333_4444);
    tick();
    expect_all("hold_neg", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    tick();
    expect_all("zero", 64'h0, 1'b1, 1'b1, 1'b0);

    drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    tick();
    expect_all("hold_zero_0", 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_all("hold_zero_1", 64'h0, 1'b0, 1'b1, 1'b0);

    // Load a nonzero negative result, then reset with valid operands present.
    drive(1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F);
    tick();
    expect_all("pre_reset", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    drive(1'b1, 64'h0000_0000_0000_0003, 64'h8000_0000_0000_0005);
    tick();
    expect_all("reset_prio", 64'h0, 1'b0, 1'b1, 1'b0);

    rst_n = 1'b1;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000);
    tick();
    expect_all("resume", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 64'h0000_0000_0000_00C3, 64'h0000_0000_0000_0055);
    tick();
    expect_all("resume_small", 64'h0000_0000_0000_0096, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 64'h0);
    tick();
    expect_all("resume_idle", 64'h0000_0000_0000_0096, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
